des_decrypt_iter: RTL and testbench

Iterative DES decryption core, the receive-side counterpart of the combinational encryption2 block. It recovers 64-bit plaintext from cipher_text produced under the same 64-bit key. One Feistel round executes per clock, using on-the-fly reverse key scheduling. It sits between the cipher-word source (file/stream reader) and the image-word sink, with valid/ready handshakes on both sides.

---
 rtl/des_pkg.sv | 136 +++++++++++++
 rtl/des_round.sv | 26 ++
 rtl/des_decrypt_iter.sv | 127 ++++++++++++
 tb/tb_des_decrypt_iter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES constants and helpers shared by the iterative decryption datapath.
// Vectors are MSB-first: DES bit 1 sits at the top index of every vector.
package des_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [4:0] LAST_ROUND = 5'd16;

    // Right-rotation applied to C,D ahead of round i+1 when walking the schedule backwards.
    localparam int unsigned DEC_SHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int unsigned FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Indexed by row*16 + column.
    localparam int unsigned SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[64-IP_T[j]];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[64-FP_T[j]];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[47-j] = x[32-E_T[j]];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int j = 0; j < 32; j++) y[31-j] = x[32-P_T[j]];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[55-j] = x[64-PC1_T[j]];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[47-j] = x[56-PC2_T[j]];
        return y;
    endfunction

    // n is the zero-based box number (0 = S1); b[5] is the first DES bit of the group.
    function automatic logic [3:0] sbox(input int unsigned n, input logic [5:0] b);
        return 4'(SBOX[n][{b[5], b[0], b[4:1]}]);
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
        case (s)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    // DES keys use odd parity per byte; any even byte is flagged.
    function automatic logic key_parity_err(input logic [63:0] k);
        logic err;
        err = 1'b0;
        for (int i = 0; i < 8; i++) if (!(^k[8*i +: 8])) err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ f(R, K).
// Direction-agnostic; an encryptor only changes the subkey sequence it feeds in.
module des_round
    import des_pkg::*;
(
    input  logic [31:0] i_l,
    input  logic [31:0] i_r,
    input  logic [47:0] i_subkey,
    output logic [31:0] o_l,
    output logic [31:0] o_r
);

    logic [47:0] w_x;
    logic [31:0] w_s;

    // Expansion, key mix and S-box substitution.
    always_comb begin
        w_s = '0;
        w_x = e_expand(i_r) ^ i_subkey;
        for (int n = 0; n < 8; n++) w_s[31-4*n -: 4] = sbox(n, w_x[47-6*n -: 6]);
    end

    assign o_l = i_r;
    assign o_r = i_l ^ p_perm(w_s);

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor: one round per clock, subkeys generated by rotating C,D right.
// 64-bit vectors carry DES bit 1 at index 63.
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter bit KEY_PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] cipher_in,
    input  logic [63:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plain_out,
    output logic        key_err
);

    state_e      r_state, w_state_next;
    logic [31:0] r_l, r_r, w_l_next, w_r_next;
    logic [27:0] r_c, r_d, w_c_next, w_d_next;
    logic [55:0] r_cd_init, w_cd_init_next;
    logic [4:0]  r_rnd, w_rnd_next;
    logic        r_out_valid, w_out_valid_next;
    logic [63:0] r_plain, w_plain_next;
    logic        r_key_err, w_key_err_next;

    logic [31:0] w_round_l, w_round_r;
    logic [47:0] w_subkey;
    logic [1:0]  w_shift;

    assign w_subkey = pc2({r_c, r_d});
    // The extra 1-bit step after round 16 brings C,D back to PC1(key).
    assign w_shift  = (r_rnd == LAST_ROUND) ? 2'd1 : 2'(DEC_SHIFT[r_rnd[3:0]]);

    des_round u_round (
        .i_l      (r_l),
        .i_r      (r_r),
        .i_subkey (w_subkey),
        .o_l      (w_round_l),
        .o_r      (w_round_r)
    );

    // Next-state and datapath update for IDLE -> BUSY (16 rounds) -> DONE.
    always_comb begin
        w_state_next     = r_state;
        w_l_next         = r_l;
        w_r_next         = r_r;
        w_c_next         = r_c;
        w_d_next         = r_d;
        w_cd_init_next   = r_cd_init;
        w_rnd_next       = r_rnd;
        w_out_valid_next = r_out_valid;
        w_plain_next     = r_plain;
        w_key_err_next   = r_key_err;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    {w_l_next, w_r_next} = ip(cipher_in);
                    {w_c_next, w_d_next} = pc1(key_in);
                    w_cd_init_next       = pc1(key_in);
                    w_rnd_next           = 5'd1;
                    w_key_err_next       = KEY_PARITY_CHECK && key_parity_err(key_in);
                    w_state_next         = BUSY;
                end
            end
            BUSY: begin
                w_l_next   = w_round_l;
                w_r_next   = w_round_r;
                w_c_next   = rotr28(r_c, w_shift);
                w_d_next   = rotr28(r_d, w_shift);
                w_rnd_next = r_rnd + 5'd1;
                if (r_rnd == LAST_ROUND) begin
                    // Halves swap before the final permutation.
                    w_plain_next     = fp({w_round_r, w_round_l});
                    w_out_valid_next = 1'b1;
                    w_state_next     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_out_valid_next = 1'b0;
                    w_state_next     = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_l         <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_cd_init   <= '0;
            r_rnd       <= '0;
            r_out_valid <= 1'b0;
            r_plain     <= '0;
            r_key_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_l         <= w_l_next;
            r_r         <= w_r_next;
            r_c         <= w_c_next;
            r_d         <= w_d_next;
            r_cd_init   <= w_cd_init_next;
            r_rnd       <= w_rnd_next;
            r_out_valid <= w_out_valid_next;
            r_plain     <= w_plain_next;
            r_key_err   <= w_key_err_next;
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign plain_out = r_plain;
    assign key_err   = r_key_err;

    // A full decryption rotates C,D by 28 bits in total.
    a_cd_restored : assert property (@(posedge clk) disable iff (rst)
        (r_state == DONE) |-> ({r_c, r_d} == r_cd_init));

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed bench for des_decrypt_iter: parity checking on (dut) and off (dut0), same stimulus.
module tb_des_decrypt_iter;

    localparam logic [63:0] FIPS_KEY    = 64'h133457799BBCDFF1;
    localparam logic [63:0] FIPS_KEY_BP = 64'h133457799BBCDFF0;
    localparam logic [63:0] FIPS_CIPHER = 64'h85E813540F0AB405;
    localparam logic [63:0] FIPS_PLAIN  = 64'h0123456789ABCDEF;
    localparam logic [63:0] WEAK_KEY    = 64'h0101010101010101;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [63:0] cipher_in, key_in;
    logic        in_ready, out_valid, key_err;
    logic [63:0] plain_out;
    logic        in_ready0, out_valid0, key_err0;
    logic [63:0] plain_out0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    des_decrypt_iter #(.KEY_PARITY_CHECK(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cipher_in (cipher_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .plain_out (plain_out),
        .key_err   (key_err)
    );

    des_decrypt_iter #(.KEY_PARITY_CHECK(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .cipher_in (cipher_in),
        .key_in    (key_in),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .plain_out (plain_out0),
        .key_err   (key_err0)
    );

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a block and let it be accepted on the next edge.
    task automatic start(input string tag, input logic [63:0] c, input logic [63:0] k);
        chk1({tag, "_ready_pre"}, in_ready, 1'b1);
        cipher_in = c;
        key_in    = k;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        chk1({tag, "_ready_busy"}, in_ready, 1'b0);
    endtask

    // Wait (bounded) for out_valid and check result, latency and both key_err flavours.
    task automatic finish_block(input string tag, input int exp_lat, input logic [63:0] exp_plain,
                                input logic exp_err, input logic exp_err0);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk_int({tag, "_latency"}, cyc, exp_lat);
        chk64({tag, "_plain"}, plain_out, exp_plain);
        chk64({tag, "_plain_p0"}, plain_out0, exp_plain);
        chk1({tag, "_key_err"}, key_err, exp_err);
        chk1({tag, "_key_err_p0"}, key_err0, exp_err0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1({tag, "_valid_drop"}, out_valid, 1'b0);
        chk1({tag, "_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cipher_in = '0;
        key_in    = '0;
        tick();
        tick();
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk64("rst_plain", plain_out, 64'h0);
        chk1("rst_key_err", key_err, 1'b0);
        rst = 1'b0;
        #1;
        chk1("idle_in_ready", in_ready, 1'b1);

        // FIPS worked example.
        start("fips", FIPS_CIPHER, FIPS_KEY);
        finish_block("fips", 16, FIPS_PLAIN, 1'b0, 1'b0);
        handshake("fips");

        // Weak key: decryption equals encryption, so known-answer encrypt vectors apply.
        start("weak1", 64'h8000000000000000, WEAK_KEY);
        finish_block("weak1", 16, 64'h95F8A5E5DD31D900, 1'b0, 1'b0);
        handshake("weak1");

        start("weak2", 64'h4000000000000000, WEAK_KEY);
        finish_block("weak2", 16, 64'hDD7F121CA5015619, 1'b0, 1'b0);
        handshake("weak2");

        // All-zero key shares PC1 with 0101..01; every byte has even parity.
        start("zero", 64'h0, 64'h0);
        finish_block("zero", 16, 64'h8CA64DE9C1B123A7, 1'b1, 1'b0);
        handshake("zero");

        // One parity bit flipped: flagged, result unchanged.
        start("parity", FIPS_CIPHER, FIPS_KEY_BP);
        finish_block("parity", 16, FIPS_PLAIN, 1'b1, 1'b0);
        handshake("parity");

        // Backpressure, with a new block waiting the whole time.
        start("bp", FIPS_CIPHER, FIPS_KEY);
        finish_block("bp", 16, FIPS_PLAIN, 1'b0, 1'b0);
        cipher_in = 64'h8000000000000000;
        key_in    = WEAK_KEY;
        in_valid  = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (plain_out !== FIPS_PLAIN || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        chk_int("bp_stable_cycles", bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("bp_hs_valid_drop", out_valid, 1'b0);
        chk1("bp_hs_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk1("bp_next_accepted", in_ready, 1'b0);
        finish_block("bp_next", 16, 64'h95F8A5E5DD31D900, 1'b0, 1'b0);
        handshake("bp_next");

        // Inputs change and in_valid pulses during BUSY: must be ignored.
        start("chg", FIPS_CIPHER, FIPS_KEY);
        repeat (4) tick();
        cipher_in = 64'hDEADBEEFCAFEF00D;
        key_in    = 64'h0;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        finish_block("chg", 11, FIPS_PLAIN, 1'b0, 1'b0);
        handshake("chg");
        tick();
        chk1("chg_no_second_accept", in_ready, 1'b1);

        // Reset at round 9 discards the block in flight.
        start("rstmid", FIPS_CIPHER, FIPS_KEY_BP);
        repeat (8) tick();
        chk1("rstmid_key_err_before", key_err, 1'b1);
        chk1("rstmid_valid_before", out_valid, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk1("rstmid_out_valid", out_valid, 1'b0);
        chk64("rstmid_plain", plain_out, 64'h0);
        chk1("rstmid_key_err", key_err, 1'b0);
        chk1("rstmid_in_ready", in_ready, 1'b1);
        repeat (20) tick();
        chk1("rstmid_discarded", out_valid, 1'b0);
        start("after_rst", FIPS_CIPHER, FIPS_KEY);
        finish_block("after_rst", 16, FIPS_PLAIN, 1'b0, 1'b0);
        handshake("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
